eth_frame_rx: RTL

// Receive-side counterpart of the ADC-to-Ethernet transmit path. Takes the byte

---
 rtl/eth_frame_rx_if.sv | 21 ++
 rtl/eth_frame_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_rx_if.sv
// rtl/eth_frame_rx_if.sv - byte-in / 40-bit-word-out bus of the Ethernet frame receiver
interface eth_frame_rx_if;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic        full;
  logic [39:0] odata;
  logic        wren;

  // master: PHY byte source plus downstream FIFO
  modport master (
    output rx_dv, rx_er, rx_data, full,
    input  odata, wren
  );

  // slave: the frame receiver
  modport slave (
    input  rx_dv, rx_er, rx_data, full,
    output odata, wren
  );
endinterface

// File: rtl/eth_frame_rx.sv
// rtl/eth_frame_rx.sv - Ethernet frame parser with 40-bit sample unpacking (FCS check under FRAME_RX_CRC_EN)
module eth_frame_rx #(
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          PAYLOAD_BYTES = 1000,
  parameter int          CNT_W         = 16
) (
  input  logic             clk125,
  input  logic             reset_n,
  eth_frame_rx_if.slave    bus,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             ovf,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_FCS,
    S_DROP
  } state_t;

  localparam logic [15:0] LAST_PAY = 16'(PAYLOAD_BYTES - 1);

  state_t      state;
  logic [15:0] cnt;      // byte index within the current section
  logic [2:0]  grp;      // bytes of the current 5-byte group already held
  logic [31:0] shreg;    // first four bytes of the group; the fifth comes straight from rx_data
  logic [7:0]  type_hi;
  logic [39:0] odata_q;
  logic        wren_q;

  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic        full;

  assign rx_dv     = bus.rx_dv;
  assign rx_er     = bus.rx_er;
  assign rx_data   = bus.rx_data;
  assign full      = bus.full;
  assign bus.odata = odata_q;
  assign bus.wren  = wren_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef FRAME_RX_CRC_EN
  // The register runs LSB-first (reflected); the residue constant is in MSB-first order.
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  logic [31:0] crc;
  logic [31:0] crc_nx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  assign crc_nx = crc_byte(crc, rx_data);
`endif

  // Frame parser FSM with word packing, status pulses and counters
  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grp       <= '0;
      shreg     <= '0;
      type_hi   <= '0;
      odata_q   <= '0;
      wren_q    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
`ifdef FRAME_RX_CRC_EN
      crc       <= 32'hFFFFFFFF;
`endif
    end else begin
      wren_q    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // Mid-frame garbage without a preamble is skipped as a whole
          if (rx_dv) begin
            state <= (rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
          end
        end
        S_PREAMBLE: begin
          if (!rx_dv) begin
            state <= S_IDLE;
          end else if (rx_er) begin
            state <= S_DROP;
          end else if (rx_data == 8'hD5) begin
            state <= S_HEADER;
            cnt   <= '0;
            grp   <= '0;
`ifdef FRAME_RX_CRC_EN
            crc   <= 32'hFFFFFFFF;
`endif
          end else if (rx_data != 8'h55) begin
            state <= S_DROP;
          end
        end
        S_HEADER, S_PAYLOAD, S_FCS: begin
          if (!rx_dv) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            state     <= S_IDLE;
          end else if (rx_er) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            state     <= S_DROP;
          end else begin
            cnt <= cnt + 16'd1;
`ifdef FRAME_RX_CRC_EN
            crc <= crc_nx;
`endif
            if (state == S_HEADER) begin
              if (cnt == 16'd12) begin
                type_hi <= rx_data;
              end
              if (cnt == 16'd13) begin
                cnt   <= '0;
                state <= ({type_hi, rx_data} == ETHERTYPE) ? S_PAYLOAD : S_DROP;
              end
            end else if (state == S_PAYLOAD) begin
              shreg <= {shreg[23:0], rx_data};
              if (grp == 3'd4) begin
                grp <= '0;
                if (full) begin
                  ovf <= 1'b1;
                end else begin
                  odata_q <= {shreg, rx_data};
                  wren_q  <= 1'b1;
                end
              end else begin
                grp <= grp + 3'd1;
              end
              if (cnt == LAST_PAY) begin
                cnt   <= '0;
                state <= S_FCS;
              end
            end else if (cnt == 16'd3) begin
              // Anything still arriving after the FCS belongs to no frame
              state <= S_DROP;
`ifdef FRAME_RX_CRC_EN
              if (bitrev(crc_nx) == RESIDUE) begin
                frame_ok  <= 1'b1;
                frame_cnt <= sat_inc(frame_cnt);
              end else begin
                frame_err <= 1'b1;
                err_cnt   <= sat_inc(err_cnt);
              end
`else
              frame_ok  <= 1'b1;
              frame_cnt <= sat_inc(frame_cnt);
`endif
            end
          end
        end
        S_DROP: begin
          if (!rx_dv) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
